alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Request-side front end for the 16-bit registered ALU. It accepts operation requests (operands, 3-bit opcode, tag) over a valid/ready handshake and buffers them in a small FIFO. It issues one operation at a time on the ALU's A/B/select inputs, waits out the ALU's registered-result latency, and returns the captured result with its tag over a second valid/ready handshake. It sits between the instruction/control logic and the ALU.

## Interface
- WIDTH, 16, operand/result width
- DEPTH, 4, request FIFO entries (power of 2, ≥2)
- RES_LAT, 1, ALU clock edges from stable select/operands to valid registered result
- TAG_W, 4, request tag width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted on clk edge when req_valid & req_ready
- req_a, req_b  in  WIDTH  operands
- req_op  in  3  opcode
- req_tag  in  TAG_W  caller tag, returned unchanged
- alu_a, alu_b  out  WIDTH  ALU operand drive, registered
- alu_sel  out  3  ALU select, registered
- alu_rst  out  1  ALU mux reset; equals rst
- alu_result  in  WIDTH  ALU registered result
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed on edge when rsp_valid & rsp_ready
- rsp_data  out  WIDTH  result
- rsp_tag  out  TAG_W  tag of the request
- busy  out  1  FSM not IDLE or FIFO non-empty
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Opcodes: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 NOT A (B ignored), 111 DIV (A/B, B=0 gives 0). All 8 codes are legal. Values pass through unmodified; no arithmetic is performed in this block.
- FIFO: req_ready = !full, forced 0 while rst. No bypass: a request always enters the FIFO. Push and pop on the same edge are allowed when not full; count is then unchanged.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head, load alu_a/alu_b/alu_sel and the tag register, load wait counter = RES_LAT, go to WAIT.
  - WAIT: decrement the counter each edge. On the edge where it is 0, capture alu_result into rsp_data, set rsp_valid, go to RESP.
  - RESP: hold rsp_data/rsp_tag/rsp_valid stable until handshake. On the handshake edge, clear rsp_valid. If the FIFO is non-empty, pop and load the next operands (go to WAIT); otherwise go to IDLE.
- alu_a/alu_b/alu_sel hold their last issued values while in IDLE/RESP and change only on pop.
- Responses are returned strictly in request order.
- Reset values: req_ready 0 during rst (1 in the cycle after rst drops); alu_a/alu_b 0; alu_sel 000; rsp_valid 0; rsp_data 0; rsp_tag 0; busy 0; count 0; FSM IDLE.
- Reset mid-operation: all queued and in-flight requests are discarded. No response is ever produced for them.

## Timing
- Acceptance on edge N, FSM idle, FIFO empty: pop on N+1, ALU registers on N+2, capture on N+3. rsp_valid is high from cycle N+3 onward. Latency = RES_LAT+2.
- Sustained throughput with rsp_ready=1: one response per RES_LAT+2 cycles (3 by default). The response handshake edge doubles as the next pop edge.
- Full: with DEPTH=4, 4 queued plus 1 in flight. req_ready drops the cycle after the 4th queued push and rises the cycle after the next pop.
- rsp_ready low: the FSM stalls in RESP and the FIFO continues to accept until full.

## Structure
- Package alu_pkg: opcode localparams (OP_AND … OP_DIV), default WIDTH, TAG_W, and the FSM state enum (IDLE, WAIT, RESP).
- Sub-module alu_req_fifo: synchronous FIFO of width 2*WIDTH+3+TAG_W with depth DEPTH. Provides push/pop/full/empty/count, same synchronous reset.
- Top contains the FSM, wait counter, operand/response registers.

## Test plan
- Single op: A=0x000C, B=0x000C, op 000, tag 1, rsp_ready=1 -> rsp_data 0x000C, tag 1, rsp_valid 3 cycles after acceptance, busy back to 0.
- Divide: A=0x0064, B=0x0007, op 111 -> 0x000E. Then B=0x0000 -> 0x0000.
- Logic sweep: A=0x10A4, B=0x1184. XNOR -> 0xFEDF, NOT -> 0xEF5B, NOR -> 0xEE5B. Issue back-to-back with rsp_ready=1 -> one response every 3 cycles, tags in order.
- Full/backpressure: rsp_ready=0, 6 requests tags 1–6. Tags 1–5 are accepted and req_ready is low for tag 6. rsp_data/tag stay stable for 10 cycles. Releasing rsp_ready returns tags 1–6 in order.
- Reset mid-operation: rst for 1 cycle while in WAIT with 3 queued -> next cycle rsp_valid 0, count 0, busy 0, alu_sel 000. No response for any flushed tag. A new request afterward completes normally.
- Simultaneous push/pop: FIFO at count 2, push on the response handshake edge -> count stays 2 and ordering is preserved.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU request sequencer: opcodes, default widths and FSM states.
package alu_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int TAG_W_DEF   = 4;
  localparam int DEPTH_DEF   = 4;
  localparam int RES_LAT_DEF = 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_DIV  = 3'b111;

  // IDLE: nothing issued | WAIT: ALU result in flight | RESP: result held for consumer
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response signal bundle between the sequencer and its neighbours.
interface alu_op_sequencer_if
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_op;
  logic [TAG_W-1:0] req_tag;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic             alu_rst;
  logic [WIDTH-1:0] alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [TAG_W-1:0] rsp_tag;

  logic             busy;
  logic [CNT_W-1:0] count;

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_sel, alu_rst, rsp_valid, rsp_data, rsp_tag,
           busy, count
  );

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_sel, alu_rst, rsp_valid, rsp_data, rsp_tag,
           busy, count
  );

endinterface

// File: rtl/alu_op_sequencer_fifo.sv
// Synchronous request FIFO; head entry is visible on o_data whenever not empty.
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter int W     = 2*WIDTH_DEF + 3 + TAG_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU requests, issues them one at a time, waits out the ALU result latency
// and returns each captured result with its tag in request order.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int RES_LAT = RES_LAT_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_op_sequencer_if.slave     sq_if
);

  localparam int EW    = 2*WIDTH + 3 + TAG_W;
  localparam int LAT_W = (RES_LAT < 1) ? 1 : $clog2(RES_LAT + 1);

  logic [1:0]              r_state;
  logic [LAT_W-1:0]        r_cnt;
  logic [WIDTH-1:0]        r_alu_a;
  logic [WIDTH-1:0]        r_alu_b;
  logic [2:0]              r_alu_sel;
  logic [TAG_W-1:0]        r_tag;
  logic                    r_rsp_valid;
  logic [WIDTH-1:0]        r_rsp_data;
  logic [TAG_W-1:0]        r_rsp_tag;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic [EW-1:0]           w_push_data;
  logic [EW-1:0]           w_head;
  logic [$clog2(DEPTH):0]  w_count;

  assign sq_if.req_ready = !w_full && !rst;
  assign w_push          = sq_if.req_valid && sq_if.req_ready;
  assign w_push_data     = {sq_if.req_a, sq_if.req_b, sq_if.req_op, sq_if.req_tag};

  // The response handshake edge doubles as the next pop edge.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_RESP) && sq_if.rsp_ready));

  alu_req_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
      r_tag     <= '0;
    end else if (w_pop) begin
      r_alu_a   <= w_head[EW-1 -: WIDTH];
      r_alu_b   <= w_head[EW-1-WIDTH -: WIDTH];
      r_alu_sel <= w_head[TAG_W+2 -: 3];
      r_tag     <= w_head[TAG_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_cnt   <= LAT_W'(RES_LAT);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_data  <= sq_if.alu_result;
            r_rsp_tag   <= r_tag;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (sq_if.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (w_pop) begin
              r_cnt   <= LAT_W'(RES_LAT);
              r_state <= ST_WAIT;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sq_if.alu_a     = r_alu_a;
  assign sq_if.alu_b     = r_alu_b;
  assign sq_if.alu_sel   = r_alu_sel;
  assign sq_if.alu_rst   = rst;
  assign sq_if.rsp_valid = r_rsp_valid;
  assign sq_if.rsp_data  = r_rsp_data;
  assign sq_if.rsp_tag   = r_rsp_tag;
  assign sq_if.busy      = (r_state != ST_IDLE) || !w_empty;
  assign sq_if.count     = w_count;

endmodule
